fp_add_sched: RTL and testbench
===============================

# fp_add_sched

Issue scheduler for the shared floating-point add/sub pipeline (unpack → add → align/normalise → pack). Arbitrates round-robin among NREQ requesters, issues one operation per cycle into the fixed-latency adder, and tracks in-flight destination tags so writebacks carry the requester ID. Provides a destination-busy scoreboard and a drain handshake for context switches and test quiescing.

## Interface
- NREQ, 4, number of requesters (2..8)
- LAT, 3, adder latency in cycles from issue_valid to result valid
- TAGW, 4, destination-register tag width (2^TAGW tags)
- IDW, 2, requester ID width, ≥ clog2(NREQ)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  request i pending
- req_a, req_b  in  NREQ*32  IEEE-754 single operands, requester i at bits [32i+31:32i]
- req_op  in  NREQ  0 = add, 1 = subtract
- req_dst  in  NREQ*TAGW  destination tag
- req_ready  out  NREQ  one-hot-or-zero grant; transfer when req_valid[i] & req_ready[i]
- issue_valid  out  1  operation presented to adder this cycle
- issue_a, issue_b  out  32  operands
- issue_op  out  1  op bit
- issue_dst  out  TAGW  destination tag
- wb_valid  out  1  adder result valid this cycle
- wb_dst  out  TAGW  tag of completing operation
- wb_id  out  IDW  requester that issued it
- drain_req  in  1  stop accepting and empty pipeline
- drained  out  1  no operation in flight and no grants

## Operation
- Grant (combinational): candidates = req_valid & ~blocked, where blocked[i] = busy[req_dst[i]] (hazard build only). No candidates or state ≠ RUN or drain_req=1 → req_ready=0.
- Priority search starts at rr_ptr, wraps modulo NREQ; first candidate granted. After grant to i, rr_ptr ← (i+1) mod NREQ; no grant → rr_ptr unchanged.
- Issue register: granted operands/op/dst latched; issue_valid=1 next cycle, else 0. issue_* data holds last value when issue_valid=0.
- Tracking pipe: LAT+1-deep shift register of {valid, dst, id} loaded alongside issue register; tail drives wb_valid/wb_dst/wb_id.
- Scoreboard busy[2^TAGW]: set at grant edge for req_dst, cleared at the edge ending the wb_valid cycle for wb_dst. Same-tag set and clear in one cycle → set wins.
- FSM: RUN → DRAIN when drain_req=1. DRAIN → DRAINED when issue register and tracking pipe all invalid. DRAINED → RUN when drain_req=0. drain_req dropping during DRAIN does not abort; DRAIN still completes via DRAINED. drained=1 only in DRAINED.

## Timing
- Reset: req_ready=0, issue_valid=0, issue_a/b=0, issue_op=0, issue_dst=0, wb_valid=0, wb_dst=0, wb_id=0, drained=0, rr_ptr=0, busy=all 0, state RUN. Reset mid-flight discards all in-flight operations; no wb_valid emitted for them.
- Grant in cycle t → issue_valid in t+1 → wb_valid in t+1+LAT.
- Throughput: one grant per cycle, back-to-back with no bubbles.
- Requester whose dst equals a completing wb_dst in cycle t is still blocked in t; eligible in t+1.
- Requester must hold req_* stable while req_valid=1 and not granted.

## Configuration
- FP_ADD_SCHED_HAZARD_EN defined: busy scoreboard built, same-tag requests blocked until writeback.
- Undefined: no scoreboard; blocked=0; requests to an in-flight tag issue immediately; all other behaviour identical.

## Test plan
- Reset with all req_valid=1 → req_ready=0, all outputs 0 during reset; first cycle after release grants requester 0.
- All four valid continuously, distinct dst → grants 0,1,2,3,0…; wb_id follows same order, each wb_valid exactly 1+LAT=4 cycles after its grant.
- Single requester 2, a=0x3F800000, b=0x40000000, op=0, dst=5 → issue_a/b/op/dst match at t+1, wb_valid with wb_dst=5, wb_id=2 at t+4.
- HAZARD_EN: req0 dst=7 granted at t, req1 dst=7 → blocked through t+4, granted t+5; without macro granted t+1.
- Three ops in flight, drain_req=1 → req_ready=0 immediately, drained=1 one cycle after last wb_valid; drain_req=0 → grants resume next cycle.
- rst_n low for one cycle with two ops in flight → no wb_valid afterwards, busy cleared, rr_ptr=0.

Source files
------------

// File: rtl/fp_add_sched.sv
// Round-robin issue scheduler for the shared FP add/sub pipeline, with in-flight tag tracking and drain handshake.
// Define FP_ADD_SCHED_HAZARD_EN to build the destination-busy scoreboard that blocks same-tag requests until writeback.
module fp_add_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int TAGW = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*TAGW-1:0] req_dst,
  output logic [NREQ-1:0]      req_ready,
  output logic                 issue_valid,
  output logic [31:0]          issue_a,
  output logic [31:0]          issue_b,
  output logic                 issue_op,
  output logic [TAGW-1:0]      issue_dst,
  output logic                 wb_valid,
  output logic [TAGW-1:0]      wb_dst,
  output logic [IDW-1:0]       wb_id,
  input  logic                 drain_req,
  output logic                 drained
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DRAINED} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_run;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW:0]    w_rr_inc;
  logic [NREQ-1:0] w_blocked;
  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_gnt_oh;
  logic            w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic [TAGW-1:0] w_gnt_dst;

  // Tracking pipe: index 0 is the issue stage, index LAT is the writeback stage.
  logic [LAT:0]    r_vld_p;
  logic [TAGW-1:0] r_dst_p [0:LAT];
  logic [IDW-1:0]  r_id_p  [0:LAT];

`ifdef FP_ADD_SCHED_HAZARD_EN
  logic [(1<<TAGW)-1:0] r_busy;

  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_blocked[i] = r_busy[req_dst[i*TAGW +: TAGW]];
    end
  end

  // Later assignment wins, so a same-tag set overrides the writeback clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (wb_valid) r_busy[wb_dst] <= 1'b0;
      if (w_gnt)    r_busy[w_gnt_dst] <= 1'b1;
    end
  end
`else
  assign w_blocked = '0;
`endif

  assign w_cand = req_valid & ~w_blocked;

  always_comb begin : p_grant
    logic [IDW:0] v_sum;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    v_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (v_sum >= (IDW+1)'(NREQ)) v_sum = v_sum - (IDW+1)'(NREQ);
      if (w_run && !w_gnt && w_cand[v_sum[IDW-1:0]]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = v_sum[IDW-1:0];
      end
    end
    if (w_gnt) w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  assign req_ready = w_gnt_oh;
  assign w_gnt_dst = req_dst[w_gnt_idx*TAGW +: TAGW];
  assign w_rr_inc  = {1'b0, w_gnt_idx} + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_gnt) begin
      r_rr_ptr <= (w_rr_inc == (IDW+1)'(NREQ)) ? '0 : w_rr_inc[IDW-1:0];
    end
  end

  // Issue stage: operands held until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_a   <= '0;
      issue_b   <= '0;
      issue_op  <= 1'b0;
      issue_dst <= '0;
    end else if (w_gnt) begin
      issue_a   <= req_a[w_gnt_idx*32 +: 32];
      issue_b   <= req_b[w_gnt_idx*32 +: 32];
      issue_op  <= req_op[w_gnt_idx];
      issue_dst <= w_gnt_dst;
    end
  end

  // Tracking stages follow the adder latency; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p <= '0;
      for (int s = 0; s <= LAT; s++) begin
        r_dst_p[s] <= '0;
        r_id_p[s]  <= '0;
      end
    end else begin
      r_vld_p <= {r_vld_p[LAT-1:0], w_gnt};
      if (w_gnt) begin
        r_dst_p[0] <= w_gnt_dst;
        r_id_p[0]  <= w_gnt_idx;
      end
      for (int s = 1; s <= LAT; s++) begin
        r_dst_p[s] <= r_dst_p[s-1];
        r_id_p[s]  <= r_id_p[s-1];
      end
    end
  end

  assign issue_valid = r_vld_p[0];
  assign wb_valid    = r_vld_p[LAT];
  assign wb_dst      = r_dst_p[LAT];
  assign wb_id       = r_id_p[LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // The writeback stage empties on this edge, so only earlier stages gate completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:     if (drain_req) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (~|r_vld_p[LAT-1:0]) w_state_nxt = S_DRAINED;
      S_DRAINED: if (!drain_req) w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_run   = (r_state == S_RUN) && !drain_req && rst_n;
    drained = (r_state == S_DRAINED);
  end

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched: reset, round-robin streaming, single-op vectors, hazard, drain and mid-flight reset.
module tb_fp_add_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int TAGW = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*TAGW-1:0] req_dst;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid;
  logic [31:0]          issue_a;
  logic [31:0]          issue_b;
  logic                 issue_op;
  logic [TAGW-1:0]      issue_dst;
  logic                 wb_valid;
  logic [TAGW-1:0]      wb_dst;
  logic [IDW-1:0]       wb_id;
  logic                 drain_req;
  logic                 drained;

  fp_add_sched #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_dst(req_dst), .req_ready(req_ready), .issue_valid(issue_valid),
    .issue_a(issue_a), .issue_b(issue_b), .issue_op(issue_op), .issue_dst(issue_dst),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_id(wb_id), .drain_req(drain_req), .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [3:0]  dst;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
  } vec_t;

  int checks = 0;
  int errors = 0;

`ifdef FP_ADD_SCHED_HAZARD_EN
  localparam int HZ_GNT_K = 5;
`else
  localparam int HZ_GNT_K = 1;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [TAGW-1:0] dst);
    req_a[id*32 +: 32]      = a;
    req_b[id*32 +: 32]      = b;
    req_op[id]              = op;
    req_dst[id*TAGW +: TAGW] = dst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   order[3];
    int   exp_k;
    vecs[0] = '{2, 32'h3F800000, 32'h40000000, 1'b0, 4'd5,  4'b0100, 2'd2};
    vecs[1] = '{0, 32'h40490FDB, 32'h3F800000, 1'b1, 4'd9,  4'b0001, 2'd0};
    vecs[2] = '{1, 32'hC0000000, 32'h40000000, 1'b0, 4'd15, 4'b0010, 2'd1};
    vecs[3] = '{3, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 4'd0,  4'b1000, 2'd3};
    order   = '{2, 0, 1};

    // Reset with every requester asserting.
    rst_n = 1'b0; drain_req = 1'b0; req_valid = '1;
    req_a = '0; req_b = '0; req_op = '0; req_dst = '0;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 32'hA0000000 | i, 32'hB0000000 | i, (i % 2) == 1, TAGW'(i));
    adv(); adv(); mid();
    chk("rst_ready", req_ready, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_a", issue_a, 0);
    chk("rst_issue_b", issue_b, 0);
    chk("rst_issue_op", issue_op, 0);
    chk("rst_issue_dst", issue_dst, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_wb_id", wb_id, 0);
    chk("rst_drained", drained, 0);
    adv();
    rst_n = 1'b1;

    // Streaming: grant cycle c goes to requester c%4 with dst tag c.
    for (int c = 0; c <= 12; c++) begin
      if (c >= 1 && c <= 8) req_dst[((c-1)%4)*TAGW +: TAGW] = TAGW'(c+3);
      req_valid = (c <= 8) ? 4'hF : 4'h0;
      mid();
      chk("rr_ready", req_ready, (c <= 8) ? (64'd1 << (c % 4)) : 64'd0);
      chk("rr_issue_valid", issue_valid, (c >= 1 && c <= 9));
      if (c >= 1 && c <= 9) begin
        chk("rr_issue_a", issue_a, 32'hA0000000 | ((c-1) % 4));
        chk("rr_issue_op", issue_op, ((c-1) % 2) == 1);
        chk("rr_issue_dst", issue_dst, c-1);
      end
      chk("rr_wb_valid", wb_valid, (c >= 4 && c <= 12));
      if (c >= 4) begin
        chk("rr_wb_dst", wb_dst, c-4);
        chk("rr_wb_id", wb_id, (c-4) % 4);
      end
      adv();
    end

    // Single-requester vectors.
    for (int v = 0; v < 4; v++) begin
      req_valid = '0;
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].dst);
      req_valid[vecs[v].id] = 1'b1;
      mid();
      chk("vec_ready", req_ready, vecs[v].exp_ready);
      adv(); req_valid = '0; mid();
      chk("vec_issue_valid", issue_valid, 1);
      chk("vec_issue_a", issue_a, vecs[v].a);
      chk("vec_issue_b", issue_b, vecs[v].b);
      chk("vec_issue_op", issue_op, vecs[v].op);
      chk("vec_issue_dst", issue_dst, vecs[v].dst);
      adv(); mid();
      chk("vec_issue_idle", issue_valid, 0);
      chk("vec_issue_hold", issue_a, vecs[v].a);
      adv(); mid();
      chk("vec_wb_early", wb_valid, 0);
      adv(); mid();
      chk("vec_wb_valid", wb_valid, 1);
      chk("vec_wb_dst", wb_dst, vecs[v].dst);
      chk("vec_wb_id", wb_id, vecs[v].exp_id);
      adv();
    end

    // Same-tag hazard: requester 1 waits on requester 0's tag 7.
    set_req(0, 32'h1, 32'h2, 1'b0, 4'd7);
    set_req(1, 32'h3, 32'h4, 1'b1, 4'd7);
    req_valid = 4'b0011;
    mid();
    chk("hz_ready0", req_ready, 4'b0001);
    adv();
    req_valid = 4'b0010;
    for (int k = 1; k <= 9; k++) begin
      mid();
      chk("hz_ready", req_ready, (k == HZ_GNT_K) ? 4'b0010 : 4'b0000);
      chk("hz_wb_valid", wb_valid, (k == 4) || (k == HZ_GNT_K + 4));
      if (k == 4) chk("hz_wb_id0", wb_id, 0);
      if (k == HZ_GNT_K + 4) begin
        chk("hz_wb_id1", wb_id, 1);
        chk("hz_wb_dst1", wb_dst, 7);
      end
      adv();
      if (k == HZ_GNT_K) req_valid = '0;
    end

    // Drain with three ops in flight, then resume.
    set_req(0, 32'h10, 32'h20, 1'b0, 4'd9);
    set_req(1, 32'h11, 32'h21, 1'b0, 4'd10);
    set_req(2, 32'h12, 32'h22, 1'b1, 4'd11);
    req_valid = 4'b0111;
    for (int d = 0; d < 3; d++) begin
      mid();
      chk("dr_ready", req_ready, 64'd1 << order[d]);
      adv();
      req_valid[order[d]] = 1'b0;
    end
    drain_req = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h50 + i, 32'h60 + i, 1'b0, TAGW'(12 + i));
    req_valid = '1;
    for (int d = 3; d <= 8; d++) begin
      if (d == 8) drain_req = 1'b0;
      mid();
      chk("dr_hold_ready", req_ready, 0);
      chk("dr_drained", drained, d >= 7);
      chk("dr_wb_valid", wb_valid, d >= 4 && d <= 6);
      adv();
    end
    mid();
    chk("dr_resume_ready", req_ready, 4'b0100);
    chk("dr_resume_drained", drained, 0);
    adv(); mid();
    chk("dr_next_ready", req_ready, 4'b1000);
    adv();

    // Reset with two ops in flight.
    rst_n = 1'b0; req_valid = '0;
    mid();
    chk("mr_rst_ready", req_ready, 0);
    adv();
    rst_n = 1'b1;
    set_req(0, 32'h77, 32'h88, 1'b0, 4'd14);
    req_valid = 4'b0001;
    mid();
    chk("mr_ready", req_ready, 4'b0001);
    chk("mr_issue_valid", issue_valid, 0);
    adv();
    req_valid = '0;
    for (int d = 13; d <= 16; d++) begin
      mid();
      exp_k = (d == 16) ? 1 : 0;
      chk("mr_wb_valid", wb_valid, exp_k);
      if (d == 16) begin
        chk("mr_wb_id", wb_id, 0);
        chk("mr_wb_dst", wb_dst, 14);
      end
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
